// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared widths, operand reset values and button index encodings
package operand_entry_pkg;
  localparam int OP_W = 16;
  localparam int NIB_W = 4;
  localparam logic [OP_W-1:0] OP1_INIT = 16'h1122;
  localparam logic [OP_W-1:0] OP2_INIT = 16'h3344;
  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
endpackage

// File: rtl/operand_entry_debounce_pulse.sv
// debounce_pulse: 2-flop synchroniser, stable-count debounce and rising-edge press pulse
//   clk, rst_n (sync, active-low) | raw: async button | level: debounced level | press: 1-cycle pulse on level rise
module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic r_s1, r_s2, r_d, r_d_q;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_d   <= 1'b0;
      r_d_q <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= raw;
      r_s2  <= r_s1;
      r_d_q <= r_d;
      // any return to the accepted level restarts the stability count
      if (r_s2 == r_d) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_d   <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign level = r_d;
  assign press = r_d & ~r_d_q;
endmodule

// File: rtl/operand_entry.sv
// operand_entry: button-driven nibble editor owning the two ALU operands
//   clk, rst_n (sync, active-low) | button[0]=inc, [1]=dec (raw) | sel_op: 0=op1,1=op2
//   sel_nib: nibble index | op1, op2: registered operands | upd: pulse when an operand changes
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [OP_W-1:0] OP1_INIT_P = OP1_INIT,
  parameter logic [OP_W-1:0] OP2_INIT_P = OP2_INIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      button,
  input  logic            sel_op,
  input  logic [1:0]      sel_nib,
  output logic [OP_W-1:0] op1,
  output logic [OP_W-1:0] op2,
  output logic            upd
);
  logic w_lvl_inc, w_lvl_dec, w_p_inc, w_p_dec, w_inc, w_dec, w_apply;
  logic [3:0] w_base;
  logic [NIB_W-1:0] w_nib;
  logic [OP_W-1:0] w_cur, w_new;
  logic [OP_W-1:0] r_op1, r_op2;
  logic r_upd;
  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst_n(rst_n), .raw(button[BTN_INC]), .level(w_lvl_inc), .press(w_p_inc)
  );
  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .rst_n(rst_n), .raw(button[BTN_DEC]), .level(w_lvl_dec), .press(w_p_dec)
  );
  // a press always coincides with a high level; coincident inc and dec cancel out
  assign w_inc   = w_p_inc & w_lvl_inc;
  assign w_dec   = w_p_dec & w_lvl_dec;
  assign w_apply = w_inc ^ w_dec;
  assign w_base  = {sel_nib, 2'b00};
  assign w_cur   = sel_op ? r_op2 : r_op1;
  assign w_nib   = w_cur[w_base +: NIB_W];
  // nibble wraps on its own, no carry or borrow into neighbours
  always_comb begin
    w_new = w_cur;
    w_new[w_base +: NIB_W] = w_inc ? w_nib + 1'b1 : w_nib - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op1 <= OP1_INIT_P;
      r_op2 <= OP2_INIT_P;
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_apply;
      if (w_apply && !sel_op) r_op1 <= w_new;
      if (w_apply && sel_op) r_op2 <= w_new;
    end
  end
  assign op1 = r_op1;
  assign op2 = r_op2;
  assign upd = r_upd;
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed self-checking bench for operand_entry with a short debounce
module tb_operand_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic sel_op = 1'b0;
  logic [1:0] sel_nib = 2'b00;
  logic [15:0] op1, op2;
  logic upd;
  int checks = 0;
  int failures = 0;
  int n_upd = 0;
  int lat = 0;
  operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .sel_op(sel_op),
    .sel_nib(sel_nib), .op1(op1), .op2(op2), .upd(upd)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (upd) n_upd++;
    end
  endtask
  task automatic press(input int b, input int hold);
    button[b] = 1'b1;
    step(hold);
    button = 2'b00;
    step(8);
  endtask
  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_op1", op1, 16'h1122);
    check("rst_op2", op2, 16'h3344);
    check("rst_upd", upd, 0);
    n_upd = 0;
    step(50);
    check("idle_upd", n_upd, 0);
    check("idle_op1", op1, 16'h1122);
    check("idle_op2", op2, 16'h3344);
    button[0] = 1'b1;
    n_upd = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (upd && lat == 0) lat = k;
    end
    check("hold_lat", (lat >= 6 && lat <= 9), 1);
    check("hold_pulses", n_upd, 1);
    check("hold_op1", op1, 16'h1123);
    check("hold_op2", op2, 16'h3344);
    button = 2'b00;
    step(10);
    check("release_pulses", n_upd, 1);
    sel_op = 1'b1;
    sel_nib = 2'd3;
    press(1, 8);
    check("dec1_op2", op2, 16'h2344);
    press(1, 8);
    check("dec2_op2", op2, 16'h1344);
    press(1, 8);
    check("dec3_op2", op2, 16'h0344);
    press(1, 8);
    check("dec_wrap_op2", op2, 16'hF344);
    check("dec_op1_kept", op1, 16'h1123);
    sel_op = 1'b0;
    sel_nib = 2'd0;
    n_upd = 0;
    for (int k = 0; k < 10; k++) begin
      button[0] = ~button[0];
      step(2);
    end
    button = 2'b00;
    step(10);
    check("bounce_upd", n_upd, 0);
    check("bounce_op1", op1, 16'h1123);
    press(0, 10);
    check("stable_pulses", n_upd, 1);
    check("stable_op1", op1, 16'h1124);
    n_upd = 0;
    button = 2'b11;
    step(12);
    button = 2'b00;
    step(8);
    check("both_upd", n_upd, 0);
    check("both_op1", op1, 16'h1124);
    check("both_op2", op2, 16'hF344);
    press(1, 8);
    press(1, 8);
    sel_nib = 2'd1;
    press(1, 8);
    press(1, 8);
    press(1, 8);
    check("setup_op1", op1, 16'h11F2);
    press(0, 8);
    check("nib_wrap_op1", op1, 16'h1102);
    check("nib_wrap_op2", op2, 16'hF344);
    sel_nib = 2'd0;
    button[0] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midrst_op1", op1, 16'h1122);
    check("midrst_op2", op2, 16'h3344);
    check("midrst_upd", upd, 0);
    n_upd = 0;
    step(5);
    check("midrst_early", n_upd, 0);
    step(15);
    check("midrst_pulses", n_upd, 1);
    check("midrst_op1_after", op1, 16'h1123);
    button = 2'b00;
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream stage of the ALU lab datapath. It owns the two 16-bit ALU operands, op1 and op2, and lets the user edit them from the board's push-buttons and switches.
- The two raw buttons are synchronised and debounced. Each clean press increments or decrements one selected hex nibble of one selected operand.
- op1/op2 feed the ALU operand inputs and the display mux directly.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new button level (10 ms at 50 MHz).
- OP1_INIT, 16'h1122: reset value of op1.
- OP2_INIT, 16'h3344: reset value of op2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- button  input  2  raw, asynchronous, active-high push-buttons; [0] = increment, [1] = decrement.
- sel_op  input  1  operand select: 0 = op1, 1 = op2 (static switch).
- sel_nib  input  2  nibble select: 0 = bits[3:0] … 3 = bits[15:12] (static switch).
- op1  output  16  operand 1, registered.
- op2  output  16  operand 2, registered.
- upd  output  1  one-cycle pulse in the cycle op1/op2 shows a new value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - op1=OP1_INIT, op2=OP2_INIT, upd=0.
  - Synchroniser flops, debounce counters and debounced levels all clear to 0.
  - Applies mid-operation as well; an in-progress debounce count is discarded.
- Per button, input synchronisation: 2-flop synchroniser on the raw input, giving s.
- Per button, debounce:
  - Debounced level d.
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If s==d: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch back to d before the count completes restarts the count.
- Per button, press pulse: p = d rising edge, a single-cycle pulse. A button held indefinitely yields exactly one pulse; there is no auto-repeat. Release produces no pulse.
- Latency: the raw level must be stable from edge N. p asserts in cycle N+2+DEBOUNCE_CYCLES (±1 for synchroniser sampling phase). op/upd update on the following edge.
- Edit rule, evaluated in the cycle p is high, with sel_op and sel_nib sampled that same cycle:
  - p_inc only: the selected nibble of the selected operand becomes nibble+1 mod 16.
  - p_dec only: the selected nibble becomes nibble−1 mod 16.
  - Wrap: F+1 -> 0 and 0−1 -> F. No carry or borrow into neighbouring nibbles.
  - The other 12 bits and the other operand are unchanged.
  - p_inc and p_dec in the same cycle: no change, upd stays 0.
- upd=1 for exactly the one cycle after an applied edit, otherwise 0.
- Switch changes without a button press never modify op1/op2.
- Button held through reset release: d=0 after reset, so the held level is debounced and counted as one press.

Decomposition:
- Shared package: OP_W=16, NIB_W=4, OP1_INIT/OP2_INIT defaults, and named encodings for button index (BTN_INC=0, BTN_DEC=1).
- One sub-module, debounce_pulse (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, level, press). It contains the synchroniser, counter and edge detect, and is instantiated twice.
- The top level holds only the edit logic and the operand registers.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
1. Release rst_n -> op1=16'h1122, op2=16'h3344, upd=0. Hold all inputs idle for 50 cycles -> no change.
2. sel_op=0, sel_nib=0; hold button[0] high for 20 cycles -> exactly one upd pulse and op1=16'h1123. Check latency against the Behaviour rule and confirm no repeat while held.
3. sel_op=1, sel_nib=3; three clean presses of button[1] -> op2 goes 0x3344 -> 0x2344 -> 0x1344 -> 0x0344. A fourth press wraps to 16'hF344 with op2[11:0] untouched.
4. Bounce: toggle button[0] every 2 cycles for 20 cycles, then release -> no upd, op1/op2 unchanged. Then a stable 10-cycle press -> exactly one increment.
5. Press both buttons so their pulses coincide -> upd=0 and no operand change. Then press only button[0] with sel_nib=1, starting from op1=0x11F2 -> op1=0x1102, with no carry into bits[11:8].
6. Assert rst_n=0 for one cycle mid-debounce (cnt=2) after op1 was edited -> op1 returns to 0x1122. A button still held afterwards produces exactly one press after a full debounce period.
